// File: rtl/rd_stream_pkg.sv
// rd_stream_sched shared definitions: defaults, FSM states
// and the per-stream base address helper.
package rd_stream_pkg;

    localparam int DEF_NUM_STREAMS          = 12;
    localparam int DEF_WRITE_STREAM_MAXSIZE = 230400;
    localparam int DEF_STREAM_ADDR_OFFSET   = $clog2(DEF_WRITE_STREAM_MAXSIZE);
    localparam int DEF_STREAM_ADDR_SHIFT    = 2;
    localparam int DEF_BEAT_BYTES           = 64;
    localparam int DEF_LONG_LEN             = 20;
    localparam int DEF_SHORT_LEN            = 4;
    localparam int DEF_SHORT_EVERY          = 4;

    localparam int STREAM_BEATS = DEF_WRITE_STREAM_MAXSIZE / DEF_BEAT_BYTES;
    localparam int BASE_SHIFT   = DEF_STREAM_ADDR_OFFSET + DEF_STREAM_ADDR_SHIFT;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DONE
    } state_t;

    function automatic logic [31:0] stream_base(
        input logic [3:0] n,
        input int         shift = BASE_SHIFT
    );
        return 32'(n) << shift;
    endfunction

endpackage

// File: rtl/rd_stream_sched.sv
// Round-robin read-command scheduler: walks each stream buffer
// with a long/short burst pattern and a trailing remainder burst.
module rd_stream_sched
    import rd_stream_pkg::*;
#(
    parameter int NUM_STREAMS          = DEF_NUM_STREAMS,
    parameter int WRITE_STREAM_MAXSIZE = DEF_WRITE_STREAM_MAXSIZE,
    parameter int STREAM_ADDR_OFFSET   = $clog2(WRITE_STREAM_MAXSIZE),
    parameter int STREAM_ADDR_SHIFT    = DEF_STREAM_ADDR_SHIFT,
    parameter int BEAT_BYTES           = DEF_BEAT_BYTES,
    parameter int LONG_LEN             = DEF_LONG_LEN,
    parameter int SHORT_LEN            = DEF_SHORT_LEN,
    parameter int SHORT_EVERY          = DEF_SHORT_EVERY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] burst_limit,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [31:0] cmd_addr,
    output logic [7:0]  cmd_len,
    output logic        cmd_last,
    output logic [3:0]  cmd_stream,
    output logic        frame_done,
    output logic        finish,
    output logic [31:0] burst_cnt
);

    localparam int BEATS  = WRITE_STREAM_MAXSIZE / BEAT_BYTES;
    localparam int SHIFT  = STREAM_ADDR_OFFSET + STREAM_ADDR_SHIFT;
    localparam int OFF_W  = $clog2(BEATS + 1);
    localparam int PIDX_W = (SHORT_EVERY > 1) ? $clog2(SHORT_EVERY) : 1;

    localparam logic [3:0]        LAST_STREAM = 4'(NUM_STREAMS - 1);
    localparam logic [PIDX_W-1:0] SHORT_IDX   = PIDX_W'(SHORT_EVERY - 1);

    if (NUM_STREAMS > 16 ||
        (64'(NUM_STREAMS) << SHIFT) > 64'h1_0000_0000) begin : g_bad_span
        $fatal(1, "stream address span does not fit in 32 bits");
    end

    if (WRITE_STREAM_MAXSIZE % BEAT_BYTES != 0) begin : g_bad_size
        $fatal(1, "stream size is not a whole number of beats");
    end

    state_t            state;
    logic [OFF_W-1:0]  off_q;
    logic [PIDX_W-1:0] pidx_q;
    logic [31:0]       lim_q;

    logic [3:0]        sel_stream;
    logic [OFF_W-1:0]  sel_off;
    logic [PIDX_W-1:0] sel_pidx;
    logic [OFF_W-1:0]  rem;
    logic [7:0]        pat;
    logic [7:0]        sel_len;
    logic              sel_last;
    logic [31:0]       sel_addr;
    logic              accept;

    assign accept = cmd_valid && cmd_ready;

    // From IDLE the selected position is the start of stream 0;
    // otherwise it is the position following the presented command.
    always_comb begin
        sel_stream = '0;
        sel_off    = '0;
        sel_pidx   = '0;
        if (state != ST_IDLE) begin
            if (cmd_last) begin
                sel_stream = (cmd_stream == LAST_STREAM)
                           ? 4'd0 : cmd_stream + 4'd1;
            end else begin
                sel_stream = cmd_stream;
                sel_off    = off_q + OFF_W'(cmd_len);
                sel_pidx   = (pidx_q == SHORT_IDX)
                           ? '0 : pidx_q + PIDX_W'(1);
            end
        end
        rem      = OFF_W'(BEATS) - sel_off;
        pat      = (sel_pidx == SHORT_IDX)
                 ? 8'(SHORT_LEN) : 8'(LONG_LEN);
        sel_len  = (32'(pat) < 32'(rem)) ? pat : 8'(rem);
        sel_last = (32'(sel_len) == 32'(rem));
        sel_addr = stream_base(sel_stream, SHIFT)
                 + 32'(sel_off) * 32'(BEAT_BYTES);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            off_q      <= '0;
            pidx_q     <= '0;
            lim_q      <= '0;
            cmd_valid  <= 1'b0;
            cmd_addr   <= '0;
            cmd_len    <= '0;
            cmd_last   <= 1'b0;
            cmd_stream <= '0;
            frame_done <= 1'b0;
            finish     <= 1'b0;
            burst_cnt  <= '0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (en) begin
                        state      <= ST_ISSUE;
                        lim_q      <= burst_limit;
                        burst_cnt  <= '0;
                        cmd_valid  <= 1'b1;
                        off_q      <= sel_off;
                        pidx_q     <= sel_pidx;
                        cmd_stream <= sel_stream;
                        cmd_addr   <= sel_addr;
                        cmd_len    <= sel_len;
                        cmd_last   <= sel_last;
                    end
                end
                ST_ISSUE: begin
                    if (accept) begin
                        burst_cnt  <= burst_cnt + 32'd1;
                        off_q      <= sel_off;
                        pidx_q     <= sel_pidx;
                        cmd_stream <= sel_stream;
                        cmd_addr   <= sel_addr;
                        cmd_len    <= sel_len;
                        cmd_last   <= sel_last;
                        frame_done <= cmd_last &&
                                      (cmd_stream == LAST_STREAM);
                        if (lim_q != '0 &&
                            burst_cnt + 32'd1 == lim_q) begin
                            state     <= ST_DONE;
                            cmd_valid <= 1'b0;
                            finish    <= 1'b1;
                        end else if (!en) begin
                            state     <= ST_IDLE;
                            cmd_valid <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    if (!en) begin
                        state  <= ST_IDLE;
                        finish <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/rd_stream_sched.md
# rd_stream_sched

Read-command scheduler feeding `read_stream`. It walks `NUM_STREAMS` frame buffers in DDR4 round-robin. For each buffer it issues a fixed pattern of long and short bursts, ending with a remainder burst. Each command is presented as an address/length pair with a valid/ready handshake, and the handshake completes on the AR acceptance of `read_stream`. `mon_streams` then checks the read data that these commands produce.

## Interface
Parameters:
- `NUM_STREAMS`, 12: number of stream buffers.
- `WRITE_STREAM_MAXSIZE`, 230400: bytes per stream.
- `STREAM_ADDR_OFFSET`, `$clog2(WRITE_STREAM_MAXSIZE)`: base exponent (18).
- `STREAM_ADDR_SHIFT`, 2: extra base shift. Stream base = `n << 20`.
- `BEAT_BYTES`, 64: bytes per AXI beat (512-bit).
- `LONG_LEN`, 20: beats per long burst.
- `SHORT_LEN`, 4: beats per short burst.
- `SHORT_EVERY`, 4: every 4th burst of a stream is short.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset, sampled on `clk` rising edge.
- `en` in 1: run enable.
- `burst_limit` in 32: total commands to issue; 0 means unlimited. Sampled on the IDLE→ISSUE transition.
- `cmd_valid` out 1: command available.
- `cmd_ready` in 1: command accepted this cycle. Driven by `ARVALID && ARREADY`.
- `cmd_addr` out 32: byte address, goes to `read_stream.addr`.
- `cmd_len` out 8: beats, goes to `read_stream.burst_length`.
- `cmd_last` out 1: this command is the final burst of its stream.
- `cmd_stream` out 4: stream index of the current command.
- `frame_done` out 1: one-cycle pulse after the last burst of stream `NUM_STREAMS-1` is accepted.
- `finish` out 1: level; high once `burst_limit` commands have been accepted.
- `burst_cnt` out 32: count of accepted commands.

## Operation
- **States:** IDLE, ISSUE, DONE.
- **IDLE → ISSUE:** when `en`=1. Load stream 0, offset 0, pattern index 0, and latch `burst_limit`.
- **ISSUE:** `cmd_valid`=1.
  - On acceptance (`cmd_valid && cmd_ready`): `burst_cnt`++ and advance the position.
  - If the limit is nonzero and `burst_cnt+1 == limit`, go to DONE.
  - Else if `en`=0, go to IDLE.
- **DONE:** `finish`=1, `cmd_valid`=0. Stays until `reset`, or until `en` falls, which returns to IDLE with `finish` cleared.
- **Length:** `pat = (pidx == SHORT_EVERY-1) ? SHORT_LEN : LONG_LEN`, then `cmd_len = min(pat, remaining_beats)`.
  - `remaining_beats = WRITE_STREAM_MAXSIZE/BEAT_BYTES - offset_beats`, which starts at 3600.
- **Address:** `(stream << (STREAM_ADDR_OFFSET+STREAM_ADDR_SHIFT)) + offset_beats*BEAT_BYTES`, computed at 32-bit width with no truncation.
- **Per-stream sequence:** 56 × (20,20,20,4), then a final burst of 16 beats at offset 0x38000. That is 225 commands per stream. `pidx` resets at every stream start.
- **Stream end:** `cmd_last = (cmd_len == remaining_beats)`.
  - On acceptance of a `cmd_last` command, the stream increments and offset/`pidx` clear.
  - Stream `NUM_STREAMS-1` wraps to 0 and pulses `frame_done`.
- **Elaboration checks:** `NUM_STREAMS << 20` must fit in 32 bits. `WRITE_STREAM_MAXSIZE` must be a multiple of `BEAT_BYTES`. Either failure is a fatal error.

## Timing
- **Reset values:** IDLE, `cmd_valid`=0, `cmd_addr`=0, `cmd_len`=0, `cmd_last`=0, `cmd_stream`=0, `frame_done`=0, `finish`=0, `burst_cnt`=0.
- **Start:** `cmd_valid` rises the cycle after `en` is sampled high in IDLE.
- **Outputs:** all registered.
- **Back-to-back:** the next command is presented in the cycle after acceptance with no bubble, so `cmd_valid` stays high.
- **Stability:** while `cmd_valid && !cmd_ready`, `cmd_addr`, `cmd_len`, `cmd_last` and `cmd_stream` hold stable. `en`=0 never withdraws a pending command; the FSM leaves ISSUE only on acceptance.
- **Simultaneous events:** if the last accepted command is both the limit and a frame end, `frame_done` and the DONE entry happen on the same edge.
- **`frame_done`:** asserted in the cycle after the accepting edge.
- **Reset mid-run:** aborts immediately to reset values. The next run restarts at stream 0, offset 0.

## Structure
- **Package `rd_stream_pkg`:**
  - Parameter defaults, `STREAM_BEATS` (3600) and the FSM state enum.
  - `stream_base(n)` function, to be shared with the benches.
- **Module:** single module with no submodule. The next-position logic (offset, `pidx`, stream) is one combinational block feeding the output registers.

## Test plan
- **Start-up:** reset, then `en`=1 with `cmd_ready`=1 → commands `(0x0,20)`, `(0x500,20)`, `(0xA00,20)`, `(0xF00,4)`, `(0x1000,20)`.
- **Stream end:** 225th command of stream 0 is `(0x38000,16,last=1)`. Next command is `(0x100000,20)` with `cmd_stream`=1.
- **Wrap:** stream 11 tail `(0xB38000,16)` accepted → `frame_done` pulses one cycle, next command is `(0x0,20)` on stream 0.
- **Backpressure:** random `cmd_ready` at 30% duty → outputs stable while stalled. The accepted sequence must be identical to the `cmd_ready`=1 run, with no skipped or duplicated commands.
- **Limit:** `burst_limit`=10000 → `finish` rises after the 10000th acceptance, `cmd_valid` is 0, and `burst_cnt`=10000.
- **Reset/en:** reset mid-stream 3 → all outputs return to reset values and restart at `(0x0,20)`. `en` dropped while stalled → the pending command is held until accepted, then IDLE.
